// File: rtl/vadd_ctrl_pkg.sv
// rtl/vadd_ctrl_pkg.sv - shared types and register map for the vadd kernel control master
package vadd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_GAP,
    ST_FIN
  } launch_state_e;

  localparam logic [7:0] REG_CTRL = 8'h00;
  localparam logic [7:0] REG_A_LO = 8'h10;
  localparam logic [7:0] REG_A_HI = 8'h14;
  localparam logic [7:0] REG_B_LO = 8'h1C;
  localparam logic [7:0] REG_B_HI = 8'h20;
  localparam logic [7:0] REG_C_LO = 8'h28;
  localparam logic [7:0] REG_C_HI = 8'h2C;
  localparam logic [7:0] REG_LEN  = 8'h34;

  localparam int AP_START = 0;
  localparam int AP_DONE  = 1;
  localparam int AP_IDLE  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Launch order: arguments first, ap_start last.
  function automatic logic [7:0] arg_offset(input logic [2:0] idx);
    case (idx)
      3'd0:    return REG_A_LO;
      3'd1:    return REG_A_HI;
      3'd2:    return REG_B_LO;
      3'd3:    return REG_B_HI;
      3'd4:    return REG_C_LO;
      3'd5:    return REG_C_HI;
      3'd6:    return REG_LEN;
      default: return REG_CTRL;
    endcase
  endfunction

endpackage

// File: rtl/axil_write_port.sv
// rtl/axil_write_port.sv - single AXI4-Lite write: independent AW/W handshakes, then B wait
module axil_write_port
  import vadd_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data,
  output logic                  aw_w_done,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp
);

  logic aw_taken;
  logic w_taken;
  logic b_wait;
  logic aw_hs;
  logic w_hs;

  always_comb begin
    awvalid    = req & ~b_wait & ~aw_taken;
    wvalid     = req & ~b_wait & ~w_taken;
    aw_hs      = awvalid & awready;
    w_hs       = wvalid & wready;
    // Both channels finished, whichever order or cycle they completed in.
    aw_w_done  = req & ~b_wait & (aw_taken | aw_hs) & (w_taken | w_hs);
    bready     = b_wait;
    resp_valid = b_wait & bvalid;
    resp_err   = resp_valid & (bresp != RESP_OKAY);
  end

  assign awaddr = addr;
  assign wdata  = data;
  assign wstrb  = 4'hF;

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_taken <= 1'b0;
      w_taken  <= 1'b0;
      b_wait   <= 1'b0;
    end else if (aw_w_done) begin
      aw_taken <= 1'b0;
      w_taken  <= 1'b0;
      b_wait   <= 1'b1;
    end else begin
      if (aw_hs)      aw_taken <= 1'b1;
      if (w_hs)       w_taken  <= 1'b1;
      if (resp_valid) b_wait   <= 1'b0;
    end
  end

endmodule

// File: rtl/vadd_launcher.sv
// rtl/vadd_launcher.sv - programs vadd kernel arguments, starts it and polls ap_done
module vadd_launcher
  import vadd_ctrl_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = 12,
  parameter int POLL_GAP        = 4,
  parameter int POLL_MAX        = 65535
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [63:0]                cmd_a,
  input  logic [63:0]                cmd_b,
  input  logic [63:0]                cmd_c,
  input  logic [31:0]                cmd_len,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [31:0]                run_cycles,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [CTRL_ADDR_WIDTH-1:0] m_awaddr,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic [31:0]                m_wdata,
  output logic [3:0]                 m_wstrb,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  input  logic [1:0]                 m_bresp,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  output logic [CTRL_ADDR_WIDTH-1:0] m_araddr,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  input  logic [31:0]                m_rdata,
  input  logic [1:0]                 m_rresp
);

  localparam logic [31:0] GAP_LEN    = 32'(POLL_GAP);
  localparam logic [31:0] POLL_LIMIT = 32'(POLL_MAX);

  launch_state_e state_q, state_d;
  logic [2:0]    idx_q;
  logic [63:0]   a_q, b_q, c_q;
  logic [31:0]   len_q;
  logic [31:0]   poll_cnt_q;
  logic [31:0]   gap_cnt_q;
  logic          poll_last;
  logic          gap_last;
  logic          rd_done;
  logic          wr_req;
  logic          wr_aw_w_done;
  logic          wr_resp_valid;
  logic          wr_resp_err;
  logic [CTRL_ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          rdata_unused;

  assign poll_last    = (poll_cnt_q + 32'd1) >= POLL_LIMIT;
  assign gap_last     = (gap_cnt_q + 32'd1) >= GAP_LEN;
  assign rd_done      = m_rdata[AP_DONE];
  assign rdata_unused = ^{m_rdata[31:AP_DONE+1], m_rdata[AP_DONE-1:0]};
  assign m_araddr     = CTRL_ADDR_WIDTH'(REG_CTRL);
  assign wr_addr      = CTRL_ADDR_WIDTH'(arg_offset(idx_q));

  always_comb begin
    case (idx_q)
      3'd0:    wr_data = a_q[31:0];
      3'd1:    wr_data = a_q[63:32];
      3'd2:    wr_data = b_q[31:0];
      3'd3:    wr_data = b_q[63:32];
      3'd4:    wr_data = c_q[31:0];
      3'd5:    wr_data = c_q[63:32];
      3'd6:    wr_data = len_q;
      default: wr_data = 32'd1 << AP_START;
    endcase
  end

  axil_write_port #(.ADDR_WIDTH(CTRL_ADDR_WIDTH)) u_wr (
    .clock      (clock),
    .reset      (reset),
    .req        (wr_req),
    .addr       (wr_addr),
    .data       (wr_data),
    .aw_w_done  (wr_aw_w_done),
    .resp_valid (wr_resp_valid),
    .resp_err   (wr_resp_err),
    .awvalid    (m_awvalid),
    .awready    (m_awready),
    .awaddr     (m_awaddr),
    .wvalid     (m_wvalid),
    .wready     (m_wready),
    .wdata      (m_wdata),
    .wstrb      (m_wstrb),
    .bvalid     (m_bvalid),
    .bready     (m_bready),
    .bresp      (m_bresp)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    wr_req    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = ST_WR;
      end
      ST_WR: begin
        wr_req = 1'b1;
        if (wr_aw_w_done) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (wr_resp_valid) begin
          if (wr_resp_err)        state_d = ST_FIN;
          else if (idx_q == 3'd7) state_d = ST_RD_ADDR;
          else                    state_d = ST_WR;
        end
      end
      ST_RD_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          if (m_rresp != RESP_OKAY || rd_done || poll_last) state_d = ST_FIN;
          else if (GAP_LEN == 32'd0)                        state_d = ST_RD_ADDR;
          else                                              state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_last) state_d = ST_RD_ADDR;
      end
      ST_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q      <= 3'd0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      len_q      <= '0;
      err        <= 1'b0;
      run_cycles <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_valid) begin
          a_q        <= cmd_a;
          b_q        <= cmd_b;
          c_q        <= cmd_c;
          len_q      <= cmd_len;
          idx_q      <= 3'd0;
          err        <= 1'b0;
          run_cycles <= '0;
          poll_cnt_q <= '0;
        end
        ST_WR_RESP: if (wr_resp_valid) begin
          if (wr_resp_err)        err   <= 1'b1;
          else if (idx_q != 3'd7) idx_q <= idx_q + 3'd1;
        end
        ST_RD_DATA: if (m_rvalid) begin
          poll_cnt_q <= poll_cnt_q + 32'd1;
          gap_cnt_q  <= '0;
          if (m_rresp != RESP_OKAY || (!rd_done && poll_last)) err <= 1'b1;
        end
        ST_GAP: gap_cnt_q <= gap_cnt_q + 32'd1;
        default: ;
      endcase
      // The kernel is running exactly while the poll loop is active.
      if ((state_q == ST_RD_ADDR || state_q == ST_RD_DATA || state_q == ST_GAP) && run_cycles != '1)
        run_cycles <= run_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_vadd_launcher.sv
// tb/tb_vadd_launcher.sv - self-checking bench for vadd_launcher with a mock kernel control slave
module tb_vadd_launcher;

  localparam int AW  = 12;
  localparam int GAP = 4;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [31:0] len;
    int          aw_dly;
    int          w_dly;
    int          berr;
    int          lat;
    logic        exp_err;
    int          exp_nwr;
  } launch_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic cmd_valid, cmd_ready, busy, done, err;
  logic [63:0] cmd_a, cmd_b, cmd_c;
  logic [31:0] cmd_len, run_cycles;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0] m_wstrb;
  logic [1:0] m_bresp, m_rresp;

  logic t_cmd_valid, t_cmd_ready, t_busy, t_done, t_err;
  logic [31:0] t_run_cycles;
  logic t_awvalid, t_wvalid, t_bready, t_arvalid, t_rready;
  logic [AW-1:0] t_awaddr, t_araddr;
  logic [31:0] t_wdata;
  logic [3:0] t_wstrb;

  vadd_launcher #(.CTRL_ADDR_WIDTH(AW), .POLL_GAP(GAP), .POLL_MAX(65535)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err), .run_cycles(run_cycles),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  // Second instance: never-done kernel, always-ready slave, short timeout, no poll gap.
  vadd_launcher #(.CTRL_ADDR_WIDTH(AW), .POLL_GAP(0), .POLL_MAX(3)) dut_to (
    .clock(clock), .reset(reset), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
    .cmd_a(64'h1000), .cmd_b(64'h2000), .cmd_c(64'h3000), .cmd_len(32'd8),
    .busy(t_busy), .done(t_done), .err(t_err), .run_cycles(t_run_cycles),
    .m_awvalid(t_awvalid), .m_awready(1'b1), .m_awaddr(t_awaddr),
    .m_wvalid(t_wvalid), .m_wready(1'b1), .m_wdata(t_wdata), .m_wstrb(t_wstrb),
    .m_bvalid(1'b1), .m_bready(t_bready), .m_bresp(2'b00),
    .m_arvalid(t_arvalid), .m_arready(1'b1), .m_araddr(t_araddr),
    .m_rvalid(1'b1), .m_rready(t_rready), .m_rdata(32'h0), .m_rresp(2'b00)
  );

  int n_vec = 0;
  int n_bad = 0;

  int aw_dly, w_dly, berr_idx, done_lat;
  int aw_cnt, w_cnt, aw_n, w_n, b_n, r_pend, cyc, start_cyc;
  int stab_err, proto_err;
  bit aw_stall, w_stall;
  logic [AW-1:0] aw_hold;
  logic [31:0] w_hold;
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  logic [31:0] rd_log[$];
  int done_cnt = 0;
  int acc_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Mock kernel control slave; decides each cycle's readies/valids at the negedge.
  initial begin
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    cyc = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; r_pend = 0; aw_stall = 0; w_stall = 0;
      end else begin
        m_bvalid = (aw_n > b_n) && (w_n > b_n);
        m_bresp  = (b_n == berr_idx) ? 2'b10 : 2'b00;
        if (m_bvalid && m_bready) b_n++;
        m_rvalid = (r_pend > 0);
        m_rdata  = (start_cyc >= 0 && done_lat >= 0 && (cyc - start_cyc) >= done_lat) ? 32'h2 : 32'h0;
        m_rresp  = 2'b00;
        if (m_rvalid && m_rready) r_pend--;
        m_arready = m_arvalid;
        if (m_arvalid) begin
          rd_log.push_back(32'(m_araddr));
          r_pend++;
        end
        if (aw_stall && (!m_awvalid || m_awaddr !== aw_hold)) stab_err++;
        m_awready = m_awvalid && (aw_cnt >= aw_dly);
        if (m_awvalid && m_awready) begin
          aw_log.push_back(32'(m_awaddr)); aw_n++; aw_cnt = 0; aw_stall = 0;
        end else if (m_awvalid) begin
          aw_cnt++; aw_stall = 1; aw_hold = m_awaddr;
        end else aw_stall = 0;
        if (w_stall && (!m_wvalid || m_wdata !== w_hold)) stab_err++;
        if (m_wvalid && m_wstrb !== 4'hF) proto_err++;
        m_wready = m_wvalid && (w_cnt >= w_dly);
        if (m_wvalid && m_wready) begin
          w_log.push_back(m_wdata); w_n++; w_cnt = 0; w_stall = 0;
          if (w_log.size() % 8 == 0) start_cyc = cyc;
        end else if (m_wvalid) begin
          w_cnt++; w_stall = 1; w_hold = m_wdata;
        end else w_stall = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (done === 1'b1) done_cnt++;
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) acc_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic slave_setup(input launch_t v);
    aw_dly = v.aw_dly; w_dly = v.w_dly; berr_idx = v.berr; done_lat = v.lat;
    aw_n = 0; w_n = 0; b_n = 0; start_cyc = -1; stab_err = 0; proto_err = 0;
    aw_log.delete(); w_log.delete(); rd_log.delete();
    cmd_a = v.a; cmd_b = v.b; cmd_c = v.c; cmd_len = v.len;
  endtask

  task automatic run_launch(input launch_t v, input string tag);
    logic [31:0] ea [8];
    logic [31:0] ed [8];
    int t, d0;
    ea = '{32'h10, 32'h14, 32'h1C, 32'h20, 32'h28, 32'h2C, 32'h34, 32'h00};
    ed = '{v.a[31:0], v.a[63:32], v.b[31:0], v.b[63:32], v.c[31:0], v.c[63:32], v.len, 32'h1};
    @(negedge clock);
    slave_setup(v);
    d0 = done_cnt;
    cmd_valid = 1;
    @(negedge clock);
    cmd_valid = 0;
    check({tag, " busy_after_accept"}, busy, 1);
    t = 0;
    while (done !== 1'b1 && t < 4000) begin
      @(negedge clock);
      t++;
    end
    check({tag, " done_seen"}, done, 1);
    check({tag, " err"}, err, v.exp_err);
    check({tag, " busy_at_done"}, busy, 0);
    if (!v.exp_err && v.lat >= 0)
      check_range({tag, " run_cycles"}, int'(run_cycles), v.lat - 3, v.lat + GAP + 3);
    @(negedge clock);
    check({tag, " done_single_pulse"}, done, 0);
    check({tag, " cmd_ready_after"}, cmd_ready, 1);
    check({tag, " done_count"}, done_cnt - d0, 1);
    check({tag, " aw_count"}, aw_log.size(), v.exp_nwr);
    check({tag, " w_count"}, w_log.size(), v.exp_nwr);
    for (int i = 0; i < v.exp_nwr && i < aw_log.size() && i < w_log.size(); i++) begin
      check($sformatf("%s waddr%0d", tag, i), aw_log[i], ea[i]);
      check($sformatf("%s wdata%0d", tag, i), w_log[i], ed[i]);
    end
    if (v.exp_err) check({tag, " no_reads"}, rd_log.size(), 0);
    else begin
      check({tag, " reads_issued"}, rd_log.size() > 0, 1);
      if (rd_log.size() > 0) check({tag, " first_araddr"}, rd_log[0], 0);
    end
    check({tag, " stable_while_stalled"}, stab_err, 0);
    check({tag, " wstrb"}, proto_err, 0);
  endtask

  launch_t vec [0:4];
  launch_t rv;
  int t, nd, a0, d0, nrd, naw, bi;

  initial begin
    reset = 1; cmd_valid = 0; t_cmd_valid = 0;
    cmd_a = 0; cmd_b = 0; cmd_c = 0; cmd_len = 0;
    aw_dly = 0; w_dly = 0; berr_idx = 100; done_lat = -1; start_cyc = -1;
    aw_n = 0; w_n = 0; b_n = 0; stab_err = 0; proto_err = 0;
    repeat (3) @(negedge clock);
    check("rst cmd_ready", cmd_ready, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst run_cycles", run_cycles, 0);
    check("rst valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    reset = 0;

    //        a             b             c             len     awd wd berr lat err nwr
    vec[0] = '{64'h100,     64'h200,      64'h300,      32'd16,  0, 0, 8,   50, 1'b0, 8};
    vec[1] = '{64'hDEAD_BEEF_0000_1000, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0000_F0F0_0040, 32'd1024, 3, 0, 8, 20, 1'b0, 8};
    vec[2] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h8000_0000_0000_0000, 64'h0000_0001_0000_0001, 32'hFFFF_FFFF, 0, 3, 8, 5, 1'b0, 8};
    vec[3] = '{64'h100,     64'h200,      64'h300,      32'd16,  1, 2, 2,   50, 1'b1, 3};
    vec[4] = '{64'hA0,      64'hB0,       64'hC0,       32'd4,   0, 0, 7,   10, 1'b1, 8};
    for (int i = 0; i < 5; i++) run_launch(vec[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      bi = int'($urandom_range(0, 11));
      rv = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), bi,
             int'($urandom_range(0, 60)), (bi < 8), (bi < 8) ? bi + 1 : 8};
      run_launch(rv, $sformatf("rnd%0d", i));
    end

    // Reset while waiting for read data, then a clean launch.
    @(negedge clock);
    slave_setup('{64'h40, 64'h80, 64'hC0, 32'd2, 0, 0, 8, -1, 1'b0, 8});
    cmd_valid = 1;
    @(negedge clock);
    cmd_valid = 0;
    t = 0;
    while (m_rready !== 1'b1 && t < 500) begin
      @(negedge clock);
      t++;
    end
    check("midrst reached_rd_data", m_rready, 1);
    reset = 1;
    @(negedge clock);
    check("midrst valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    check("midrst cmd_ready", cmd_ready, 1);
    check("midrst busy", busy, 0);
    check("midrst run_cycles", run_cycles, 0);
    @(negedge clock);
    reset = 0;
    run_launch(vec[0], "post_reset");

    // cmd_valid held high across two complete runs.
    @(negedge clock);
    slave_setup('{64'h1, 64'h2, 64'h3, 32'd3, 1, 2, 100, 10, 1'b0, 8});
    a0 = acc_cnt; d0 = done_cnt; nd = 0; t = 0;
    cmd_valid = 1;
    while (nd < 2 && t < 4000) begin
      @(negedge clock);
      t++;
      if (done === 1'b1) nd++;
    end
    cmd_valid = 0;
    repeat (5) @(negedge clock);
    check("b2b accepts", acc_cnt - a0, 2);
    check("b2b done_pulses", done_cnt - d0, 2);
    check("b2b writes", aw_log.size(), 16);
    check("b2b err", err, 0);

    // Timeout instance: exactly POLL_MAX status reads, then err.
    @(negedge clock);
    t_cmd_valid = 1;
    @(negedge clock);
    t_cmd_valid = 0;
    nrd = 0; naw = 0; t = 0;
    while (t_done !== 1'b1 && t < 300) begin
      if (t_arvalid === 1'b1) nrd++;
      if (t_awvalid === 1'b1) naw++;
      @(negedge clock);
      t++;
    end
    check("timeout done_seen", t_done, 1);
    check("timeout reads", nrd, 3);
    check("timeout writes", naw, 8);
    check("timeout err", t_err, 1);
    @(negedge clock);
    check("timeout cmd_ready", t_cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vadd_launcher.md
Name: vadd_launcher

Overview:
- AXI4-Lite master that sequences the vadd kernel through its control slave port (s_axi_control), replacing direct MMIO pokes.
- Accepts one launch command (three buffer pointers plus element count), programs the kernel argument registers, writes ap_start, then polls ap_done.
- Reports completion, error status and elapsed kernel cycles.
- Sits in top between the test/host side and the kernel control port.

Parameters:
- CTRL_ADDR_WIDTH, 12, AXI4-Lite address width of the kernel control port.
- POLL_GAP, 4, idle cycles between consecutive status reads (0 allowed).
- POLL_MAX, 65535, status reads without ap_done before a timeout is declared.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  launch request.
- cmd_ready  out  1  high only in IDLE.
- cmd_a  in  64  source A byte address.
- cmd_b  in  64  source B byte address.
- cmd_c  in  64  destination byte address.
- cmd_len  in  32  element count.
- busy  out  1  high from command accept until the done pulse.
- done  out  1  one-cycle completion pulse.
- err  out  1  status of the last launch, valid from done onward: 1 = bad response or timeout.
- run_cycles  out  32  cycles from ap_start write accept to ap_done observed; saturates at all-ones.
- m_awvalid out 1; m_awready in 1; m_awaddr out CTRL_ADDR_WIDTH.
- m_wvalid out 1; m_wready in 1; m_wdata out 32; m_wstrb out 4.
- m_bvalid in 1; m_bready out 1; m_bresp in 2.
- m_arvalid out 1; m_arready in 1; m_araddr out CTRL_ADDR_WIDTH.
- m_rvalid in 1; m_rready out 1; m_rdata in 32; m_rresp in 2.

Behaviour:
- Reset: all valid/ready outputs 0 except cmd_ready=1; busy=0, done=0, err=0, run_cycles=0; FSM in IDLE; write index=0.
- Reset mid-operation: abort immediately. No valid remains asserted the cycle after reset.
- IDLE:
  - On cmd_valid&cmd_ready, register all arguments, clear err and run_cycles, set busy, go to WR.
  - cmd_* are ignored while busy.
- Write sequence, index 0..7, fixed order:
  - 0x10 a[31:0], 0x14 a[63:32]
  - 0x1C b[31:0], 0x20 b[63:32]
  - 0x28 c[31:0], 0x2C c[63:32]
  - 0x34 len
  - 0x00 data 0x1 (ap_start)
  - wstrb=0xF for all writes.
- WR:
  - Assert awvalid and wvalid in the same cycle.
  - Each drops independently after its own handshake; both handshakes may occur in the same cycle or in either order.
  - Once both have completed, go to WR_RESP.
- WR_RESP:
  - m_bready=1.
  - On bvalid: if bresp≠0, set err and go to FIN. Otherwise increment the index, or go to RD_ADDR after index 7.
  - run_cycles starts counting the cycle after the index-7 B handshake.
- RD_ADDR: arvalid=1, araddr=0x00; hold until arready, then go to RD_DATA.
- RD_DATA:
  - m_rready=1.
  - On rvalid:
    - rresp≠0 → err=1, go to FIN.
    - rdata[1]=1 (ap_done) → go to FIN.
    - Poll count reached POLL_MAX → err=1, go to FIN.
    - Otherwise → GAP.
- GAP: wait POLL_GAP cycles, then go to RD_ADDR. With POLL_GAP=0, GAP lasts 0 cycles (RD_DATA goes directly to RD_ADDR).
- FIN:
  - done=1 for one cycle; busy drops in the same cycle; return to IDLE.
  - run_cycles stops counting and holds until the next accept.
- No address or data changes while valid is high and unacknowledged.
- At most one outstanding transaction.

Decomposition:
- Package vadd_ctrl_pkg holds:
  - FSM state enum.
  - Register offset constants: CTRL=0x00, A_LO=0x10, A_HI=0x14, B_LO=0x1C, B_HI=0x20, C_LO=0x28, C_HI=0x2C, LEN=0x34.
  - Control bit positions: AP_START=0, AP_DONE=1, AP_IDLE=2.
  - AXI response codes.
- One sub-module, axil_write_port: the AW/W independent-handshake tracker plus B wait. It is reused later for other control masters.

Test Plan:
- Launch with a=0x100, b=0x200, c=0x300, len=16 against an always-ready slave:
  - Eight writes appear in order with the exact address/data listed above.
  - The first read targets 0x00.
  - A mock kernel sets ap_done after 50 cycles → single done pulse, err=0, run_cycles in 50±(POLL_GAP+3).
- Slave with awready delayed 3 cycles and wready immediate (then the reverse):
  - Each write completes exactly once.
  - No duplicate AW or W handshakes.
  - Address/data are stable while stalled.
- bresp=2 on the third write → no further AW or AR issued; done with err=1; cmd_ready high the next cycle.
- POLL_MAX=3 with ap_done never set → exactly 3 status reads; done with err=1.
- Assert reset during RD_DATA → all valids 0 the next cycle, cmd_ready=1, busy=0; a new launch then completes normally.
- cmd_valid held high through a whole run → exactly one launch accepted per IDLE visit; back-to-back launches give two done pulses.
